// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: drains an async FIFO read port into a 2-entry valid/ready output buffer.
// Define FIFO_RD_STATS_EN to build the delivered-word and stall counters.
module fifo_rd_drain #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_,
    output logic             fifo_rden,
    input  logic [WIDTH-1:0] fifo_dataout,
    input  logic             fifo_rdempty,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [31:0]      stat_words,
    output logic [15:0]      stat_stall
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
    occ_e             occ_q, occ_d;
    logic             pend_q, drop_q, drop_d;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic             pop, cap;
    logic [2:0]       credit;

    assign pop       = out_valid & out_ready & ~flush;
    assign cap       = pend_q & ~drop_q;
    // pop implies occ >= 1, so this 3-bit sum never underflows
    assign credit    = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    assign fifo_rden = reset_ & ~flush & ~fifo_rdempty & (credit < 3'd2);
    assign out_valid = (occ_q != EMPTY) & ~flush;
    assign out_data  = head_q;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        drop_d = flush & (pend_q | fifo_rden);
        if (flush) begin
            occ_d = EMPTY;
        end else begin
            case (occ_q)
                EMPTY: if (cap) begin
                    head_d = fifo_dataout;
                    occ_d  = ONE;
                end
                ONE: begin
                    if (cap && pop) begin
                        head_d = fifo_dataout;
                    end else if (cap) begin
                        tail_d = fifo_dataout;
                        occ_d  = TWO;
                    end else if (pop) begin
                        occ_d = EMPTY;
                    end
                end
                default: if (pop) begin
                    head_d = tail_q;
                    tail_d = fifo_dataout;
                    occ_d  = cap ? TWO : ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            occ_q  <= EMPTY;
            pend_q <= 1'b0;
            drop_q <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= fifo_rden;
            drop_q <= drop_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // The credit rule makes this unreachable; a hit means a word would be lost.
    assert property (@(posedge clk) disable iff (!reset_) !(cap && occ_q == TWO && !pop));

`ifdef FIFO_RD_STATS_EN
    logic [31:0] words_q;
    logic [15:0] stall_q;
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_q + {31'd0, pop};
            stall_q <= (out_valid && !out_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        end
    end
    assign stat_words = words_q;
    assign stat_stall = stall_q;
`else
    assign stat_words = '0;
    assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: scoreboard bench; a word enters the scoreboard when it is read from the
// FIFO model and leaves when the DUT hands it over (or a flush/reset discards it).
module tb_fifo_rd_drain;
    localparam int W = 8;
    logic clk = 1'b0, reset_ = 1'b1, fifo_rden, fifo_rdempty = 1'b1, flush = 1'b0;
    logic out_valid, out_ready = 1'b0;
    logic [W-1:0] fifo_dataout = '0, out_data;
    logic [31:0] stat_words;
    logic [15:0] stat_stall;

    typedef struct {logic [W-1:0] d; int c;} ent_t;
    ent_t sb[$];
    logic [W-1:0] src[$];
    int n_chk = 0, n_fail = 0, cyc = 0, n_rd = 0, n_del = 0, base;
    logic rd_fire = 1'b0, force_empty = 1'b0, m_pop, exp_valid;
    logic [W-1:0] rd_word = '0;
    logic [31:0] m_words = '0;
    logic [15:0] m_stall = '0;

    always #5 clk = ~clk;

    fifo_rd_drain #(.WIDTH(W)) dut (
        .clk(clk), .reset_(reset_), .fifo_rden(fifo_rden), .fifo_dataout(fifo_dataout),
        .fifo_rdempty(fifo_rdempty), .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .stat_words(stat_words), .stat_stall(stat_stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: values at the falling edge are what the next rising edge will see.
    always @(negedge clk) begin
        cyc++;
        if (!reset_) begin
            rd_fire = 1'b0;
        end else begin
            m_pop     = out_valid && out_ready && !flush;
            exp_valid = !flush && sb.size() > 0 && cyc >= sb[0].c + 2;
            check("occupancy", sb.size() <= 2, 1);
            check("out_valid", out_valid, exp_valid);
            if (out_valid && sb.size() > 0) check("out_data", out_data, sb[0].d);
            check("rden_rule", fifo_rden, !flush && !fifo_rdempty && (sb.size() - int'(m_pop)) < 2);
            if (fifo_rden) check("rden_guard", {fifo_rdempty, flush}, 0);
`ifdef FIFO_RD_STATS_EN
            check("stat_words", stat_words, m_words);
            check("stat_stall", stat_stall, 32'(m_stall));
`else
            check("stat_words", stat_words, 0);
            check("stat_stall", stat_stall, 0);
`endif
            if (m_pop && sb.size() > 0) begin
                void'(sb.pop_front());
                n_del++;
                m_words++;
            end
            if (out_valid && !out_ready && m_stall != 16'hFFFF) m_stall++;
            if (flush) sb.delete();
            rd_fire = fifo_rden && src.size() > 0;
            if (rd_fire) begin
                rd_word = src.pop_front();
                sb.push_back('{rd_word, cyc});
                n_rd++;
            end
        end
    end

    task automatic step(input logic fl, input logic rdy, input int push);
        @(posedge clk);
        #1;
        fifo_dataout = rd_fire ? rd_word : W'($urandom);
        for (int i = 0; i < push; i++) src.push_back(W'($urandom));
        flush        = fl;
        out_ready    = rdy;
        fifo_rdempty = force_empty || src.size() == 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_rden"}, fifo_rden, 0);
        check({tag, "_words"}, stat_words, 0);
        check({tag, "_stall"}, stat_stall, 0);
    endtask

    initial begin
        #1 reset_ = 1'b0;
        #2 check_reset_outputs("rst0");
        @(posedge clk);
        #1 reset_ = 1'b1;
        // back-to-back stream with a ready sink
        n_del = 0;
        step(0, 1, 4);
        repeat (8) step(0, 1, 0);
        check("p1_delivered", n_del, 4);
`ifdef FIFO_RD_STATS_EN
        check("p1_stat_words", stat_words, 4);
`else
        check("p1_stat_words", stat_words, 0);
`endif
        // backpressure: only two reads may be outstanding
        n_del = 0;
        base  = n_rd;
        step(0, 0, 5);
        repeat (6) step(0, 0, 0);
        check("p2_reads", n_rd - base, 2);
        repeat (10) step(0, 1, 0);
        check("p2_delivered", n_del, 5);
        // alternating ready
        n_del = 0;
        step(0, 1, 8);
        for (int i = 0; i < 20; i++) step(0, (i % 2) == 0, 0);
        repeat (4) step(0, 1, 0);
        check("p3_delivered", n_del, 8);
        // flush with a full buffer drops both held words
        n_del = 0;
        step(0, 0, 4);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        repeat (8) step(0, 1, 0);
        check("p4_delivered", n_del, 2);
        // empty flag toggling under a continuous stream
        for (int i = 0; i < 30; i++) begin
            force_empty = (i % 2) == 1;
            step(0, 1, 1);
        end
        force_empty = 1'b0;
        repeat (10) step(0, 1, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            force_empty = ($urandom % 4) == 0;
            step(($urandom % 16) == 0, ($urandom % 3) != 0, int'($urandom % 2));
        end
        force_empty = 1'b0;
        for (int i = 0; i < 50 && (src.size() + sb.size()) > 0; i++) step(0, 1, 0);
        check("drain", src.size() + sb.size(), 0);
        // asynchronous reset with a full buffer
        step(0, 0, 3);
        repeat (5) step(0, 0, 0);
        check("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #3 reset_ = 1'b0;
        #1 check_reset_outputs("rst1");
        sb.delete();
        src.delete();
        m_words      = '0;
        m_stall      = '0;
        fifo_rdempty = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        check("post_rst_words", stat_words, 0);
        check("post_rst_stall", stat_stall, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
